// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing the global register bus between host (H) and sequencer (S).
// One outstanding transaction: one-cycle enable pulse, read wait with timeout, completion pulse.
module mm_bus_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = 64'hDEAD_DEAD_DEAD_DEAD
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              iH_REQ,
    input  logic              iH_WR,
    input  logic [ADDR_W-1:0] iH_ADDR,
    input  logic [DATA_W-1:0] iH_WR_DATA,
    output logic              oH_GNT,
    output logic              oH_DONE,
    output logic              oH_ERR,
    output logic [DATA_W-1:0] oH_RD_DATA,

    input  logic              iS_REQ,
    input  logic              iS_WR,
    input  logic [ADDR_W-1:0] iS_ADDR,
    input  logic [DATA_W-1:0] iS_WR_DATA,
    output logic              oS_GNT,
    output logic              oS_DONE,
    output logic              oS_ERR,
    output logic [DATA_W-1:0] oS_RD_DATA,

    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,

    output logic [15:0]       oSTRAY_CNT,
    output logic [15:0]       oTMO_CNT
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state;
    logic        owner_s;
    logic        last_gnt_s;
    logic        is_wr;
    logic [15:0] wait_cnt;
    logic        pick_s;

    // On a tie the requester not granted last wins; last_gnt_s=1 means S was last.
    assign pick_s = iS_REQ && (!iH_REQ || !last_gnt_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_s     <= 1'b0;
            last_gnt_s  <= 1'b1;
            is_wr       <= 1'b0;
            wait_cnt    <= '0;
            oH_GNT      <= 1'b0;
            oH_DONE     <= 1'b0;
            oH_ERR      <= 1'b0;
            oH_RD_DATA  <= '0;
            oS_GNT      <= 1'b0;
            oS_DONE     <= 1'b0;
            oS_ERR      <= 1'b0;
            oS_RD_DATA  <= '0;
            oMM_WR_EN   <= 1'b0;
            oMM_RD_EN   <= 1'b0;
            oMM_ADDR    <= '0;
            oMM_WR_DATA <= '0;
            oSTRAY_CNT  <= '0;
            oTMO_CNT    <= '0;
        end else begin
            oH_GNT    <= 1'b0;
            oS_GNT    <= 1'b0;
            oH_DONE   <= 1'b0;
            oS_DONE   <= 1'b0;
            oH_ERR    <= 1'b0;
            oS_ERR    <= 1'b0;
            oMM_WR_EN <= 1'b0;
            oMM_RD_EN <= 1'b0;

            if (iMM_RD_DATA_V && state != WAIT)
                oSTRAY_CNT <= sat_inc16(oSTRAY_CNT);

            case (state)
                IDLE: begin
                    if (iH_REQ || iS_REQ) begin
                        owner_s     <= pick_s;
                        is_wr       <= pick_s ? iS_WR : iH_WR;
                        oMM_ADDR    <= pick_s ? iS_ADDR : iH_ADDR;
                        oMM_WR_DATA <= pick_s ? iS_WR_DATA : iH_WR_DATA;
                        oMM_WR_EN   <= pick_s ? iS_WR : iH_WR;
                        oMM_RD_EN   <= pick_s ? !iS_WR : !iH_WR;
                        oH_GNT      <= !pick_s;
                        oS_GNT      <= pick_s;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_gnt_s <= owner_s;
                    if (is_wr) begin
                        oH_DONE <= !owner_s;
                        oS_DONE <= owner_s;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Valid data takes priority over a timeout expiring in the same cycle.
                    if (iMM_RD_DATA_V) begin
                        if (owner_s) oS_RD_DATA <= iMM_RD_DATA;
                        else         oH_RD_DATA <= iMM_RD_DATA;
                        oH_DONE <= !owner_s;
                        oS_DONE <= owner_s;
                        state   <= RESP;
                    end else if (wait_cnt == TMO_LAST) begin
                        if (owner_s) oS_RD_DATA <= ERR_DATA;
                        else         oH_RD_DATA <= ERR_DATA;
                        oH_DONE  <= !owner_s;
                        oS_DONE  <= owner_s;
                        oH_ERR   <= !owner_s;
                        oS_ERR   <= owner_s;
                        oTMO_CNT <= sat_inc16(oTMO_CNT);
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mm_bus_arbiter.md
# mm_bus_arbiter

Two-requester arbiter and sequencer for the global register bus. It sits in front of the global address decoder and shares the single memory-mapped port between the host interface (H) and the internal configuration sequencer (S). It grants requesters round-robin and allows one outstanding transaction. Each transaction is issued as a one-cycle enable pulse; the arbiter waits for read data with a timeout and returns a completion pulse to the granted requester.

## Interface
- ADDR_W, 17, register address width
- DATA_W, 64, data width
- TIMEOUT_CYC, 256, maximum WAIT cycles before a read is abandoned (legal range 2..65535)
- ERR_DATA, 64'hDEAD_DEAD_DEAD_DEAD, read data returned on timeout

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- iH_REQ  in  1  host request; held with fields stable until oH_GNT
- iH_WR  in  1  1 = write, 0 = read
- iH_ADDR  in  ADDR_W  host address
- iH_WR_DATA  in  DATA_W  host write data
- oH_GNT  out  1  one-cycle pulse: host request accepted and issued
- oH_DONE  out  1  one-cycle completion pulse
- oH_ERR  out  1  valid with oH_DONE: read timed out
- oH_RD_DATA  out  DATA_W  read data, updated only on oH_DONE of a read, held otherwise
- iS_REQ, iS_WR, iS_ADDR, iS_WR_DATA, oS_GNT, oS_DONE, oS_ERR, oS_RD_DATA: identical set for the sequencer
- oMM_WR_EN  out  1  decoder write enable (one-cycle pulse)
- oMM_RD_EN  out  1  decoder read enable (one-cycle pulse)
- oMM_ADDR  out  ADDR_W  decoder address, held from ISSUE until the next ISSUE
- oMM_WR_DATA  out  DATA_W  decoder write data, held like oMM_ADDR
- iMM_RD_DATA  in  DATA_W  decoder read data
- iMM_RD_DATA_V  in  1  decoder read data valid
- oSTRAY_CNT  out  16  saturating count of iMM_RD_DATA_V pulses seen outside WAIT
- oTMO_CNT  out  16  saturating count of read timeouts

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample iH_REQ and iS_REQ.
  - If only one is high, select it.
  - If both are high, select the one that was not granted last. The last_gnt bit resets to S, so H wins the first tie.
  - On selection, latch WR, ADDR and WR_DATA into oMM_ADDR/oMM_WR_DATA, record the owner, and go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert oMM_WR_EN or oMM_RD_EN and the owner's GNT; update last_gnt.
  - Write: go to RESP. Read: clear the timeout counter and go to WAIT.
- WAIT:
  - If iMM_RD_DATA_V=1, capture iMM_RD_DATA, clear err, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC-1 with no valid, set err, load ERR_DATA, increment oTMO_CNT (saturating), and go to RESP.
  - If valid and timeout coincide, valid wins and no error is flagged.
- RESP (one cycle):
  - Pulse the owner's DONE; drive ERR=err for a read timeout and 0 otherwise.
  - For a read, update the owner's RD_DATA.
  - Go to IDLE.
- iMM_RD_DATA_V outside WAIT (late data after a timeout, or a spurious pulse):
  - Ignored for data; no DONE is produced.
  - oSTRAY_CNT increments, saturating at 16'hFFFF.
- The non-owner's outputs never pulse. REQ from a requester is ignored outside IDLE.

## Timing
- Reset values:
  - All GNT/DONE/ERR and oMM_*_EN are 0.
  - oMM_ADDR, oMM_WR_DATA and both RD_DATA are 0.
  - Counters are 0, state is IDLE, last_gnt = S.
- All outputs are registered; there is no combinational path from an input to an output.
- REQ sampled at cycle T:
  - T+1: MM enable and GNT.
  - Write: DONE at T+2, IDLE at T+3. The next grant enables at T+4, so writes are spaced 3 cycles apart.
  - Read: valid arriving k cycles after ISSUE (k≥1) gives DONE at T+1+k+1.
  - Timeout: DONE at T+1+TIMEOUT_CYC+1.
- Requester rule:
  - Deassert REQ in the cycle after GNT, or keep it high to request again. A REQ still high in IDLE is a new request.
  - Under continuous contention, grants alternate H,S,H,S.
- Reset asserted mid-transaction aborts it immediately:
  - No DONE is produced and counters clear.
  - Any data arriving after reset deassertion counts as stray.

## Test plan
- H write alone: iH_REQ=1, WR=1, ADDR=17'h00010, DATA=64'h1234 at T.
  - oMM_WR_EN=1 with ADDR 17'h00010 and DATA 64'h1234 at T+1, and oH_GNT=1 at T+1.
  - oH_DONE=1 with oH_ERR=0 at T+2. The S outputs stay 0.
- S read, valid 3 cycles after ISSUE with data 64'hCAFE.
  - oMM_RD_EN at T+1; oS_DONE at T+5 with oS_RD_DATA=64'hCAFE and oS_ERR=0.
  - oH_RD_DATA unchanged.
- Both request reads continuously, each with valid 1 cycle after ISSUE.
  - Grant order is H,S,H,S.
  - No two enables occur within 3 cycles of each other.
- Timeout with TIMEOUT_CYC=4 and no valid:
  - oH_DONE with oH_ERR=1 and RD_DATA=ERR_DATA at ISSUE+5; oTMO_CNT=1.
  - A late valid afterwards gives oSTRAY_CNT=1 and no DONE.
- Valid in the same cycle the timeout expires: DONE with ERR=0, the captured data, and oTMO_CNT unchanged.
- rst_n pulsed low during WAIT:
  - All outputs return to their reset values and no DONE is produced.
  - After release, an H write completes normally with DONE at T+2.
